// File: rtl/booth_pkg.sv
// Shared types and the radix-4 Booth recoding function for the sequential multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        BD_ZERO = 3'd0,
        BD_POS1 = 3'd1,
        BD_POS2 = 3'd2,
        BD_NEG1 = 3'd3,
        BD_NEG2 = 3'd4
    } booth_digit_t;

    // Triplet is {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_digit_t booth_recode(input logic [2:0] triplet);
        booth_digit_t digit;
        digit = BD_ZERO;
        case (triplet)
            3'b001, 3'b010: digit = BD_POS1;
            3'b011:         digit = BD_POS2;
            3'b100:         digit = BD_NEG2;
            3'b101, 3'b110: digit = BD_NEG1;
            default:        digit = BD_ZERO;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Request/response bundle between the control unit and the Booth multiplier.
interface booth_mult_seq_if #(
    parameter int WIDTH = 8
) ();
    // Handshake: start_i is sampled only while the engine is idle (busy_o low); once
    // accepted, a_i/b_i are captured and ignored until the run ends. done_o pulses for
    // exactly one cycle with product_o valid, and product_o holds until the next accept.
    logic                 start_i;
    logic [WIDTH-1:0]     a_i;
    logic [WIDTH-1:0]     b_i;
    logic                 busy_o;
    logic                 done_o;
    logic [2*WIDTH-1:0]   product_o;

    modport master (
        output start_i, a_i, b_i,
        input  busy_o, done_o, product_o
    );

    modport slave (
        input  start_i, a_i, b_i,
        output busy_o, done_o, product_o
    );
endinterface

// File: rtl/booth_pp_gen.sv
// Combinational radix-4 Booth partial product: selects 0, +/-A or +/-2A at 2*WIDTH bits.
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [2:0]         triplet,
    output logic [2*WIDTH-1:0] pp
);
    localparam int PW = 2 * WIDTH;

    logic [PW-1:0] a_ext;
    logic [PW-1:0] a_neg;

    // Sign-extend before negating so -(-2^(WIDTH-1)) is representable.
    assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    assign a_neg = ~a_ext + PW'(1);

    always_comb begin
        pp = '0;
        unique case (booth_recode(triplet))
            BD_ZERO: pp = '0;
            BD_POS1: pp = a_ext;
            BD_POS2: pp = {a_ext[PW-2:0], 1'b0};
            BD_NEG1: pp = a_neg;
            BD_NEG2: pp = {a_neg[PW-2:0], 1'b0};
            default: pp = '0;
        endcase
    end
endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier: one recoded digit accumulated per clock through one adder.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    booth_mult_seq_if.slave   bus,
    output state_t            dbg_state
);
    localparam int PW     = 2 * WIDTH;
    localparam int DIGITS = WIDTH / 2;
    localparam int CNT_W  = $clog2(DIGITS) + 1;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     product;
    logic [CNT_W-1:0]  cnt;

    logic [WIDTH:0]    b_ext;
    logic [2:0]        triplet;
    logic [PW-1:0]     pp;
    logic [PW-1:0]     pp_shift;
    logic [PW-1:0]     acc_sum;
    logic              accept;
    logic              busy;
    logic              done;
    logic              last_digit;

    // Appending b[-1]=0 lets every digit use the same 3-bit window.
    assign b_ext = {b_reg, 1'b0};

    always_comb begin
        triplet = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt == CNT_W'(i)) begin
                triplet = b_ext[2*i +: 3];
            end
        end
    end

    booth_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
        .a       (a_reg),
        .triplet (triplet),
        .pp      (pp)
    );

    assign pp_shift   = pp << {cnt, 1'b0};
    assign acc_sum    = acc + pp_shift;
    assign last_digit = (cnt == CNT_W'(DIGITS - 1));

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_digit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_reg <= bus.a_i;
                b_reg <= bus.b_i;
                acc   <= '0;
                cnt   <= '0;
            end else if (state == RUN) begin
                acc <= acc_sum;
                cnt <= cnt + CNT_W'(1);
                // Load the final sum on the edge into DONE so product_o is valid with done_o.
                if (last_digit) begin
                    product <= acc_sum;
                end
            end
        end
    end

    assign bus.busy_o    = busy;
    assign bus.done_o    = done;
    assign bus.product_o = product;
    assign dbg_state     = state;
endmodule
